// File: rtl/pool_2x2_feeder.sv
// Streams a raster fp16 feature map into a 2x2 max-pool unit: even rows are buffered,
// odd rows issue an upper-pair/lower-pair operand sequence per 2x2 window.
module pool_2x2_feeder #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] pool_a,
  output logic [15:0] pool_b,
  output logic        pool_store,
  output logic        pool_out_valid,
  output logic [((IMG_H/2 > 1) ? $clog2(IMG_H/2) : 1)-1:0] pool_row,
  output logic [((IMG_W/2 > 1) ? $clog2(IMG_W/2) : 1)-1:0] pool_col,
  output logic        frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = (IMG_W/2 > 1) ? $clog2(IMG_W/2) : 1;
  localparam int RW = (IMG_H/2 > 1) ? $clog2(IMG_H/2) : 1;
  localparam int NP = IMG_W / 2;

  typedef enum logic [1:0] {IDLE, FILL, POOL, DONE} state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   in_col;
  logic [YW-1:0]   in_row;
  logic [15:0]     stage;
  logic [31:0]     rbuf [NP];
  logic [31:0]     iss_pair;
  logic [CW-1:0]   iss_idx;
  logic [RW-1:0]   iss_row;
  logic            s1, s2;
  logic            take, col_last, row_last, drained;
  logic [CW-1:0]   pair_idx;

  assign take     = in_valid & in_ready;
  assign col_last = (in_col == XW'(IMG_W - 1));
  assign row_last = (in_row == YW'(IMG_H - 1));
  assign pair_idx = CW'(in_col >> 1);
  // After the last pixel the row counter has wrapped to 0 while still in POOL;
  // input is closed and DONE waits for the final result to leave the pipeline.
  assign drained  = (in_row == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = FILL;
      FILL: if (take && col_last) state_nx = POOL;
      POOL: begin
        if (take && col_last && !row_last) state_nx = FILL;
        else if (drained && s2)            state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state == FILL) || ((state == POOL) && !drained);
    frame_done     = (state == DONE);
    pool_store     = s1;
    pool_out_valid = s2;
    pool_a         = '0;
    pool_b         = '0;
    pool_row       = '0;
    pool_col       = '0;
    if (s1) begin
      {pool_a, pool_b} = rbuf[iss_idx];
    end else if (s2) begin
      {pool_a, pool_b} = iss_pair;
      pool_row         = iss_row;
      pool_col         = iss_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col <= '0;
      in_row <= '0;
    end else if (take) begin
      if (col_last) begin
        in_col <= '0;
        in_row <= row_last ? '0 : in_row + YW'(1);
      end else begin
        in_col <= in_col + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage    <= '0;
      iss_pair <= '0;
      iss_idx  <= '0;
      iss_row  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
    end else begin
      s1 <= 1'b0;
      s2 <= s1;
      if (take && !in_col[0]) stage <= in_data;
      if (take && in_col[0] && (state == POOL)) begin
        iss_pair <= {stage, in_data};
        iss_idx  <= pair_idx;
        iss_row  <= RW'(in_row >> 1);
        s1       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && in_col[0] && (state == FILL)) rbuf[pair_idx] <= {stage, in_data};
  end

endmodule

// File: doc/pool_2x2_feeder.md
POOL_2X2_FEEDER -- requirements
Module: pool_2x2_feeder

Interface
REQ-001 Parameter IMG_W, default 24, feature-map width in pixels; even, >= 2.
REQ-002 Parameter IMG_H, default 24, feature-map height in pixels; even, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a frame from IDLE; ignored outside IDLE.
REQ-006 in_valid  input  1  in_data holds a valid fp16 pixel.
REQ-007 in_data  input  16  fp16 pixel, raster order (row-major, column 0 first).
REQ-008 in_ready  output  1  feeder accepts pixel; transfer when in_valid and in_ready both high.
REQ-009 pool_a  output  16  left fp16 operand to the 2x2 max-pool unit.
REQ-010 pool_b  output  16  right fp16 operand to the 2x2 max-pool unit.
REQ-011 pool_store  output  1  pool unit latches max(pool_a,pool_b) this cycle.
REQ-012 pool_out_valid  output  1  pool unit's combinational pooled result is valid this cycle.
REQ-013 pool_row  output  $clog2(IMG_H/2)  output-map row of the current result.
REQ-014 pool_col  output  $clog2(IMG_W/2)  output-map column of the current result.
REQ-015 frame_done  output  1  one-cycle pulse after the last pooled result of a frame.

Function
REQ-016 FSM states IDLE, FILL (even input row), POOL (odd input row), DONE.
REQ-017 IDLE -> FILL on start; FILL -> POOL after pixel IMG_W-1 of an even row; POOL -> FILL after pixel IMG_W-1 of an odd row unless it is row IMG_H-1; then POOL -> DONE; DONE -> IDLE after one cycle.
REQ-018 in_ready high in FILL and POOL, low in IDLE and DONE.
REQ-019 Counters in_col (0..IMG_W-1) and in_row (0..IMG_H-1) advance only on accepted pixels; in_col wraps to 0 and in_row increments at column IMG_W-1.
REQ-020 FILL: even-column pixel held in a staging register; on the odd-column pixel, the {even,odd} pair is written to row-buffer entry in_col/2 (IMG_W/2 entries x 32 bits).
REQ-021 POOL: even-column pixel staged; on the odd-column pixel accepted in cycle T, the current pair and index in_col/2 are latched into an issue register.
REQ-022 Cycle T+1: pool_a/pool_b = row-buffer entry in_col/2 (upper row), pool_store = 1, pool_out_valid = 0.
REQ-023 Cycle T+2: pool_a/pool_b = issue-register pair (lower row), pool_store = 0, pool_out_valid = 1, pool_row = in_row/2, pool_col = index.
REQ-024 Issue is a 2-stage pipeline overlapping acceptance of the next pair; full 1 pixel/cycle throughput with no input stall; the next pair cannot issue before T+3.
REQ-025 Gaps in in_valid allowed anywhere; no issue cycle occurs without an accepted odd-column pixel in POOL.
REQ-026 Outside REQ-022/023 cycles: pool_store = 0, pool_out_valid = 0, pool_a/pool_b = 16'h0000.
REQ-027 frame_done asserts the cycle after the last pool_out_valid (row IMG_H/2-1, col IMG_W/2-1), coincident with DONE.
REQ-028 No fp16 arithmetic in this block; pixels pass bit-exact.
REQ-029 start while not IDLE has no effect.

Reset
REQ-030 rst_n low asynchronously forces IDLE, counters 0, staging/issue registers 0, all outputs 0 (in_ready 0, pool_store 0, pool_out_valid 0, frame_done 0, pool_a/pool_b/pool_row/pool_col 0).
REQ-031 Row-buffer contents need not be reset; never read before written in the same frame.
REQ-032 Reset mid-frame abandons the frame: no further pool_store/pool_out_valid until a new start completes FILL of row 0.

Verification
REQ-033 IMG_W=4, IMG_H=2, start, pixels 1..8 (fp16) back-to-back -> pool_store with (1,2) then out_valid with (5,6) col 0; store (3,4), out_valid (7,8) col 1; frame_done one cycle after the last out_valid.
REQ-034 Same frame with in_valid toggled 1-0-1-0 -> identical issue sequence and values, only spaced later; no spurious store/out_valid.
REQ-035 IMG_W=24, IMG_H=24 full frame with scoreboard model of pool unit (max over 2x2) -> 144 out_valid pulses, rows/cols 0..11 raster order, all maxima match.
REQ-036 Negative fp16 pixels (e.g. 16'hBC00, 16'hC000) -> operands bit-exact on pool_a/pool_b.
REQ-037 rst_n low during POOL row 1, then start, new frame -> outputs all 0 during reset; new frame results correct, none from old frame.
REQ-038 start pulsed during FILL -> ignored; counters and results unaffected.
